tiny_fir_tap_loader: RTL and testbench

TINY_FIR_TAP_LOADER -- requirements
Module: tiny_fir_tap_loader

---
 rtl/tiny_fir_tap_loader.sv | 163 ++++++++++++++++
 tb/tb_tiny_fir_tap_loader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tiny_fir_tap_loader.sv
// Coefficient store plus streaming loader that pushes G_NUM_TAPS taps into a FIR programming port.
// Optional done-wait timeout enabled by defining TINY_FIR_TAP_LOADER_TIMEOUT_EN.
module tiny_fir_tap_loader #(
   parameter int unsigned G_NUM_TAPS       = 16,
   parameter int unsigned G_TAP_WIDTH      = 16,
   parameter int unsigned G_TIMEOUT_CYCLES = 1024
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic [$clog2(G_NUM_TAPS)-1:0] cfg_addr,
   input  logic [G_TAP_WIDTH-1:0]        cfg_data,
   input  logic                          cfg_wr,
   input  logic                          start,
   output logic                          busy,
   output logic                          load_done,
   output logic                          error,
   output logic [G_TAP_WIDTH-1:0]        tap_dout,
   output logic                          tap_dout_valid,
   input  logic                          tap_dout_ready,
   input  logic                          tap_dout_done
);

   localparam int unsigned IdxW = $clog2(G_NUM_TAPS);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(G_NUM_TAPS - 1);

   if ((G_NUM_TAPS < 2) || ((G_NUM_TAPS & (G_NUM_TAPS - 1)) != 0) || (G_TIMEOUT_CYCLES == 0))
   begin : g_bad_params
      $error("tiny_fir_tap_loader: invalid parameter set");
   end

   typedef enum logic [2:0] {
      SM_IDLE,
      SM_SEND,
      SM_WAIT_DONE,
      SM_DONE,
      SM_ERROR
   } state_e;

   state_e                 state_q, state_d;
   logic [IdxW-1:0]        idx_q, idx_d;
   logic [G_TAP_WIDTH-1:0] tap_q, tap_d;
   logic                   valid_q, valid_d;
   logic [G_TAP_WIDTH-1:0] coef_q [G_NUM_TAPS];
   logic [IdxW-1:0]        idx_nxt;
   logic                   cfg_we;

`ifdef TINY_FIR_TAP_LOADER_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(G_TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(G_TIMEOUT_CYCLES - 1);
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            err_q, err_d;
`endif

   assign busy           = (state_q == SM_SEND) || (state_q == SM_WAIT_DONE);
   assign load_done      = (state_q == SM_DONE);
   assign tap_dout       = tap_q;
   assign tap_dout_valid = valid_q;
   assign idx_nxt        = idx_q + IdxW'(1);
   assign cfg_we         = cfg_wr && !busy;

`ifdef TINY_FIR_TAP_LOADER_TIMEOUT_EN
   assign error = err_q;
`else
   assign error = 1'b0;
`endif

   // Storage is deliberately unreset; only the controller returns to a known state.
   always_ff @(posedge clk) begin
      if (cfg_we) begin
         coef_q[cfg_addr] <= cfg_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= SM_IDLE;
         idx_q   <= '0;
         tap_q   <= '0;
         valid_q <= 1'b0;
`ifdef TINY_FIR_TAP_LOADER_TIMEOUT_EN
         cnt_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         tap_q   <= tap_d;
         valid_q <= valid_d;
`ifdef TINY_FIR_TAP_LOADER_TIMEOUT_EN
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      tap_d   = tap_q;
      valid_d = valid_q;
`ifdef TINY_FIR_TAP_LOADER_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = err_q;
`endif
      if (!enable) begin
         state_d = SM_IDLE;
         idx_d   = '0;
         tap_d   = '0;
         valid_d = 1'b0;
`ifdef TINY_FIR_TAP_LOADER_TIMEOUT_EN
         cnt_d   = '0;
         err_d   = 1'b0;
`endif
      end else begin
         unique case (state_q)
            SM_IDLE, SM_DONE, SM_ERROR: begin
               if (start) begin
                  state_d = SM_SEND;
                  idx_d   = '0;
                  valid_d = 1'b1;
                  // A same-cycle write to tap 0 must be the value sent first.
                  tap_d   = (cfg_wr && (cfg_addr == '0)) ? cfg_data : coef_q[0];
`ifdef TINY_FIR_TAP_LOADER_TIMEOUT_EN
                  err_d   = 1'b0;
`endif
               end else if (state_q == SM_DONE) begin
                  state_d = SM_IDLE;
               end
            end
            SM_SEND: begin
               if (valid_q && tap_dout_ready) begin
                  if (idx_q == LastIdx) begin
                     valid_d = 1'b0;
                     state_d = SM_WAIT_DONE;
`ifdef TINY_FIR_TAP_LOADER_TIMEOUT_EN
                     cnt_d   = '0;
`endif
                  end else begin
                     idx_d = idx_nxt;
                     tap_d = coef_q[idx_nxt];
                  end
               end
            end
            SM_WAIT_DONE: begin
               if (tap_dout_done) begin
                  state_d = SM_DONE;
               end
`ifdef TINY_FIR_TAP_LOADER_TIMEOUT_EN
               else if (cnt_q == CntLast) begin
                  state_d = SM_ERROR;
                  err_d   = 1'b1;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
`endif
            end
            default: state_d = SM_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tiny_fir_tap_loader.sv
// Directed bench for tiny_fir_tap_loader: a queue of expected beats (snapshot of the written
// coefficients at each accepted start) is checked against every handshake.
module tb_tiny_fir_tap_loader;

`ifdef TINY_FIR_TAP_LOADER_TIMEOUT_EN
   localparam int unsigned TO = 8;
`else
   localparam int unsigned TO = 1024;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b1;
   logic [3:0]  cfg_addr = '0;
   logic [15:0] cfg_data = '0;
   logic        cfg_wr = 1'b0;
   logic        start = 1'b0;
   logic        busy, load_done, error;
   logic [15:0] tap_dout;
   logic        tap_dout_valid;
   logic        tap_dout_ready = 1'b0;
   logic        tap_dout_done = 1'b0;

   tiny_fir_tap_loader #(
      .G_NUM_TAPS      (16),
      .G_TAP_WIDTH     (16),
      .G_TIMEOUT_CYCLES(TO)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .cfg_addr      (cfg_addr),
      .cfg_data      (cfg_data),
      .cfg_wr        (cfg_wr),
      .start         (start),
      .busy          (busy),
      .load_done     (load_done),
      .error         (error),
      .tap_dout      (tap_dout),
      .tap_dout_valid(tap_dout_valid),
      .tap_dout_ready(tap_dout_ready),
      .tap_dout_done (tap_dout_done)
   );

   always #5 clk = ~clk;

   logic [15:0] mem [16];
   logic [15:0] exp_q [$];
   logic [15:0] beat_log [64];
   int          beat_count = 0;
   int          ld_pulses = 0;
   int          ld_base = 0;
   int          n_cmp = 0;
   int          n_err = 0;

   logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_en = 1'b0, prev_rst = 1'b1;
   logic [15:0] prev_dout = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
      end
   endtask

   // Per-cycle comparison against the expected-beat queue and the hold rule.
   always @(negedge clk) begin
      logic [15:0] e;
      if (!reset && enable && tap_dout_valid && tap_dout_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL extra_beat: got 0x%0h required no beat", tap_dout);
         end else begin
            e = exp_q.pop_front();
            check("beat_data", {16'h0, tap_dout}, {16'h0, e});
         end
         if (beat_count < 64) beat_log[beat_count] = tap_dout;
         beat_count++;
      end
      if (prev_valid && !prev_ready && prev_en && !prev_rst && enable) begin
         check("hold_valid", {31'h0, tap_dout_valid}, 32'h1);
         check("hold_data", {16'h0, tap_dout}, {16'h0, prev_dout});
      end
      if (!reset && load_done) ld_pulses++;
      prev_valid = tap_dout_valid;
      prev_ready = tap_dout_ready;
      prev_en    = enable;
      prev_rst   = reset;
      prev_dout  = tap_dout;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [15:0] d, input bit takes_effect);
      cfg_addr = a;
      cfg_data = d;
      cfg_wr   = 1'b1;
      tick();
      cfg_wr = 1'b0;
      if (takes_effect) mem[a] = d;
   endtask

   task automatic accept_start();
      for (int i = 0; i < 16; i++) exp_q.push_back(mem[i]);
      beat_count = 0;
      ld_base    = ld_pulses;
      check("busy_after_start", {31'h0, busy}, 32'h1);
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      accept_start();
   endtask

   task automatic start_with_write(input logic [3:0] a, input logic [15:0] d);
      cfg_addr = a;
      cfg_data = d;
      cfg_wr   = 1'b1;
      start    = 1'b1;
      tick();
      cfg_wr = 1'b0;
      start  = 1'b0;
      mem[a] = d;
      accept_start();
   endtask

   task automatic run_load(input int bound, input bit toggle, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < bound; c++) begin
         @(posedge clk);
         #1;
         if (toggle) tap_dout_ready = ~tap_dout_ready;
         @(negedge clk);
         #1;
         if (ld_pulses != ld_base) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic finish_load(input bit ok);
      check("load_done_seen", {31'h0, ok}, 32'h1);
      check("busy_at_done", {31'h0, busy}, 32'h0);
      check("beat_count", beat_count, 16);
      check("queue_drained", exp_q.size(), 0);
      repeat (3) tick();
      check("load_done_pulses", ld_pulses - ld_base, 1);
      check("error_clear", {31'h0, error}, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit ok;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_load_done", {31'h0, load_done}, 32'h0);
      check("rst_error", {31'h0, error}, 32'h0);
      check("rst_valid", {31'h0, tap_dout_valid}, 32'h0);
      check("rst_dout", {16'h0, tap_dout}, 32'h0);
      reset = 1'b0;
      tick();
      for (int i = 0; i < 16; i++) wr(4'(i), 16'(i + 1), 1'b1);

      // Ready held high, done high.
      tap_dout_done  = 1'b1;
      tap_dout_ready = 1'b1;
      do_start();
      run_load(100, 1'b0, ok);
      finish_load(ok);
      check("lit_beat0", {16'h0, beat_log[0]}, 32'h0001);
      check("lit_beat7", {16'h0, beat_log[7]}, 32'h0008);
      check("lit_beat15", {16'h0, beat_log[15]}, 32'h0010);

      // Ready toggling every cycle.
      do_start();
      run_load(200, 1'b1, ok);
      finish_load(ok);
      check("lit_toggle_beat15", {16'h0, beat_log[15]}, 32'h0010);

      // Write while busy is ignored.
      tap_dout_ready = 1'b0;
      do_start();
      tick();
      wr(4'd3, 16'hBEEF, 1'b0);
      tap_dout_ready = 1'b1;
      run_load(100, 1'b0, ok);
      finish_load(ok);
      do_start();
      run_load(100, 1'b0, ok);
      finish_load(ok);
      check("lit_coef3_kept", {16'h0, beat_log[3]}, 32'h0004);

      // Second start during SEND is ignored.
      do_start();
      repeat (3) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      run_load(100, 1'b0, ok);
      finish_load(ok);

      // Enable dropped after beat 5, then a clean restart.
      do_start();
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         #1;
         if (beat_count >= 5) break;
      end
      check("beats_before_drop", beat_count, 5);
      @(posedge clk);
      #1;
      enable = 1'b0;
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      check("drop_busy", {31'h0, busy}, 32'h0);
      check("drop_valid", {31'h0, tap_dout_valid}, 32'h0);
      check("drop_dout", {16'h0, tap_dout}, 32'h0);
      check("drop_no_done", ld_pulses - ld_base, 0);
      enable = 1'b1;
      tick();
      do_start();
      run_load(100, 1'b0, ok);
      finish_load(ok);
      check("lit_restart_beat0", {16'h0, beat_log[0]}, 32'h0001);

      // Start together with a write to tap 0.
      start_with_write(4'd0, 16'h1234);
      run_load(100, 1'b0, ok);
      finish_load(ok);
      check("lit_same_cycle_wr", {16'h0, beat_log[0]}, 32'h1234);
      check("lit_same_cycle_beat1", {16'h0, beat_log[1]}, 32'h0002);

      tap_dout_done = 1'b0;
`ifdef TINY_FIR_TAP_LOADER_TIMEOUT_EN
      do_start();
      ok = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         #1;
         if (error) begin
            ok = 1'b1;
            break;
         end
      end
      check("timeout_error", {31'h0, error}, 32'h1);
      check("timeout_busy", {31'h0, busy}, 32'h0);
      check("timeout_beats", beat_count, 16);
      check("timeout_no_done", ld_pulses - ld_base, 0);
      do_start();
      check("start_clears_error", {31'h0, error}, 32'h0);
      tap_dout_done = 1'b1;
      run_load(100, 1'b0, ok);
      finish_load(ok);
`else
      do_start();
      repeat (60) tick();
      check("wait_busy", {31'h0, busy}, 32'h1);
      check("wait_error", {31'h0, error}, 32'h0);
      check("wait_no_done", ld_pulses - ld_base, 0);
      check("wait_beats", beat_count, 16);
      tap_dout_done = 1'b1;
      run_load(20, 1'b0, ok);
      finish_load(ok);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
